// File: rtl/iiq_issue_select.sv
// iiq_issue_select: CDB wakeup, oldest-ready select and issue register for the integer issue queue.
// Define IIQ_WAKEUP_BYPASS_EN to let an entry woken this cycle be selected in the same cycle.
module iiq_issue_select #(
    parameter int N_ENTRIES = 8,
    parameter int TAG_WIDTH = 6,
    parameter int PAYLOAD_WIDTH = 40,
    parameter int N_CDB = 2,
    localparam int ENTRY_WIDTH = PAYLOAD_WIDTH + 3*TAG_WIDTH + 2,
    localparam int CTR_WIDTH = $clog2(N_ENTRIES) + 1
) (
    input  logic                             clk,
    input  logic                             rst_aH,
    input  logic                             flush,
    input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] q_entries,
    input  logic [CTR_WIDTH-1:0]             q_count,
    output logic                             q_deq_ready,
    output logic [N_ENTRIES-1:0]             q_deq_sel_onehot,
    output logic [N_ENTRIES-1:0]             q_wr_en,
    output logic [N_ENTRIES*ENTRY_WIDTH-1:0] q_wr_data,
    input  logic [N_CDB-1:0]                 cdb_valid,
    input  logic [N_CDB*TAG_WIDTH-1:0]       cdb_tag,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [ENTRY_WIDTH-1:0]           iss_data
);
    localparam int R1 = TAG_WIDTH;
    localparam int T2 = TAG_WIDTH + 1;
    localparam int R2 = 2*TAG_WIDTH + 1;

    logic [ENTRY_WIDTH-1:0] ent [N_ENTRIES];
    logic [ENTRY_WIDTH-1:0] woken [N_ENTRIES];
    logic [N_ENTRIES-1:0]   valid, hit1, hit2, cand, pick;
    logic [ENTRY_WIDTH-1:0] pick_data;
    logic                   can_load;

    always_comb begin
        valid = '0;
        hit1 = '0;
        hit2 = '0;
        cand = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            ent[i] = q_entries[i*ENTRY_WIDTH +: ENTRY_WIDTH];
            valid[i] = CTR_WIDTH'(i) < q_count;
            for (int k = 0; k < N_CDB; k++) begin
                hit1[i] = hit1[i] | (cdb_valid[k] & (cdb_tag[k*TAG_WIDTH +: TAG_WIDTH] == ent[i][TAG_WIDTH-1:0]));
                hit2[i] = hit2[i] | (cdb_valid[k] & (cdb_tag[k*TAG_WIDTH +: TAG_WIDTH] == ent[i][T2 +: TAG_WIDTH]));
            end
            woken[i] = ent[i];
            woken[i][R1] = ent[i][R1] | hit1[i];
            woken[i][R2] = ent[i][R2] | hit2[i];
`ifdef IIQ_WAKEUP_BYPASS_EN
            cand[i] = valid[i] & woken[i][R1] & woken[i][R2];
`else
            cand[i] = valid[i] & ent[i][R1] & ent[i][R2];
`endif
        end
    end

    // Isolating the lowest set bit gives oldest-first priority.
    assign pick = cand & (~cand + 1'b1);
    assign can_load = ~iss_valid | iss_ready;
    assign q_deq_ready = can_load & ~flush;
    assign q_deq_sel_onehot = q_deq_ready ? pick : '0;

    // An entry leaving the queue this cycle must not be rewritten.
    always_comb begin
        q_wr_en = '0;
        q_wr_data = '0;
        pick_data = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            q_wr_en[i] = valid[i] & ((hit1[i] & ~ent[i][R1]) | (hit2[i] & ~ent[i][R2]))
                         & ~q_deq_sel_onehot[i] & ~flush;
            q_wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = woken[i];
            pick_data = pick_data | ({ENTRY_WIDTH{pick[i]}} & woken[i]);
        end
        pick_data[R1] = 1'b1;
        pick_data[R2] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            iss_valid <= 1'b0;
            iss_data <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (|q_deq_sel_onehot) begin
            iss_valid <= 1'b1;
            iss_data <= pick_data;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end
endmodule
